// File: rtl/conv_calc_param_if.sv
// conv_calc_param_if: window, coefficient-config and result channels of the conv engine.
interface conv_calc_param_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_FILT = 8,
    parameter int CFG_AW   = 10
);
    logic                         win_valid;
    logic                         win_ready;
    logic [9*DATA_W-1:0]          win_data;
    logic                         cfg_we;
    logic [CFG_AW-1:0]            cfg_addr;
    logic [DATA_W-1:0]            cfg_data;
    logic                         cfg_err;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_FILT*DATA_W-1:0]   out_data;
    logic [NUM_FILT-1:0]          out_sat;

    modport master (
        output win_valid, win_data, cfg_we, cfg_addr, cfg_data, out_ready,
        input  win_ready, cfg_err, out_valid, out_data, out_sat
    );
    modport slave (
        input  win_valid, win_data, cfg_we, cfg_addr, cfg_data, out_ready,
        output win_ready, cfg_err, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/conv_calc_param.sv
// conv_calc_param: multi-channel 3x3 convolution for NUM_FILT filters with bias, shift, saturation and ReLU.
module conv_calc_param #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int IN_CH    = 8,
    parameter int NUM_FILT = 8,
    parameter int FRAC_W   = 8,
    parameter int RELU_EN  = 1,
    localparam int CFG_AW  = $clog2(NUM_FILT*(IN_CH*9+1))
) (
    input logic clk,
    input logic rst_n,
    conv_calc_param_if.slave bus
);
    localparam int PER_F = IN_CH*9+1;
    localparam int DEPTH = NUM_FILT*PER_F;
    localparam int CW    = IN_CH > 1 ? $clog2(IN_CH) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {ACCUM, FINISH, OUT} state_t;

    state_t                     state_q;
    logic [CW-1:0]              ch_cnt_q;
    logic signed [ACC_W-1:0]    acc_q [NUM_FILT];
    logic signed [ACC_W-1:0]    acc_d [NUM_FILT];
    logic signed [DATA_W-1:0]   coef_q [DEPTH];
    logic signed [DATA_W-1:0]   res_d [NUM_FILT];
    logic [NUM_FILT-1:0]        sat_d;
    logic [NUM_FILT*DATA_W-1:0] out_data_q;
    logic [NUM_FILT-1:0]        out_sat_q;
    logic                       cfg_err_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    r;
    logic [CFG_AW-1:0]          base;
    logic                       hs;
    logic                       cfg_ok;
    logic                       last_ch;

    // Ready is gated by reset so it rises the moment reset is released.
    assign bus.win_ready = (state_q == ACCUM) && !rst_n;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.cfg_err   = cfg_err_q;
    assign hs      = bus.win_valid && bus.win_ready;
    assign last_ch = (ch_cnt_q == CW'(IN_CH-1));
    assign cfg_ok  = (state_q == ACCUM) && (ch_cnt_q == '0) && !hs && (32'(bus.cfg_addr) < DEPTH);

    always_comb begin
        prod = '0;
        r    = '0;
        base = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            acc_d[f] = acc_q[f];
            res_d[f] = '0;
            sat_d[f] = 1'b0;
        end
        for (int f = 0; f < NUM_FILT; f++) begin
            base = CFG_AW'(f*PER_F) + CFG_AW'(ch_cnt_q) * CFG_AW'(9);
            for (int k = 0; k < 9; k++) begin
                prod     = $signed(bus.win_data[k*DATA_W +: DATA_W]) * coef_q[base + CFG_AW'(k)];
                acc_d[f] = acc_d[f] + ACC_W'(prod);
            end
            r        = (acc_q[f] + ACC_W'(coef_q[CFG_AW'(f*PER_F + IN_CH*9)])) >>> FRAC_W;
            sat_d[f] = (r > MAXV) || (r < MINV);
            r        = r > MAXV ? MAXV : r < MINV ? MINV : r;
            res_d[f] = (RELU_EN != 0 && r < 0) ? '0 : r[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= ACCUM;
            ch_cnt_q   <= '0;
            cfg_err_q  <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= '0;
            for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= '0;
            for (int i = 0; i < DEPTH; i++) coef_q[i] <= '0;
        end else begin
            cfg_err_q <= bus.cfg_we && !cfg_ok;
            if (bus.cfg_we && cfg_ok) coef_q[bus.cfg_addr] <= bus.cfg_data;
            case (state_q)
                ACCUM: if (hs) begin
                    for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= acc_d[f];
                    ch_cnt_q <= last_ch ? '0 : ch_cnt_q + 1'b1;
                    state_q  <= last_ch ? FINISH : ACCUM;
                end
                FINISH: begin
                    for (int f = 0; f < NUM_FILT; f++) out_data_q[f*DATA_W +: DATA_W] <= res_d[f];
                    out_sat_q <= sat_d;
                    state_q   <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= '0;
                    state_q <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_calc_param.sv
// tb_conv_calc_param: directed bench; three DUTs share stimulus and differ in FRAC_W/RELU_EN.
module tb_conv_calc_param;
    localparam int DW = 16;
    localparam int IC = 2;
    localparam int NF = 2;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_calc_param_if #(.DATA_W(DW), .NUM_FILT(NF), .CFG_AW(AW)) ifa ();
    conv_calc_param_if #(.DATA_W(DW), .NUM_FILT(NF), .CFG_AW(AW)) ifb ();
    conv_calc_param_if #(.DATA_W(DW), .NUM_FILT(NF), .CFG_AW(AW)) ifc ();

    assign ifb.win_valid = ifa.win_valid;
    assign ifb.win_data  = ifa.win_data;
    assign ifb.cfg_we    = ifa.cfg_we;
    assign ifb.cfg_addr  = ifa.cfg_addr;
    assign ifb.cfg_data  = ifa.cfg_data;
    assign ifb.out_ready = ifa.out_ready;
    assign ifc.win_valid = ifa.win_valid;
    assign ifc.win_data  = ifa.win_data;
    assign ifc.cfg_we    = ifa.cfg_we;
    assign ifc.cfg_addr  = ifa.cfg_addr;
    assign ifc.cfg_data  = ifa.cfg_data;
    assign ifc.out_ready = ifa.out_ready;

    conv_calc_param #(.DATA_W(DW), .ACC_W(40), .IN_CH(IC), .NUM_FILT(NF), .FRAC_W(0), .RELU_EN(1))
        dut (.clk(clk), .rst_n(rst), .bus(ifa));
    conv_calc_param #(.DATA_W(DW), .ACC_W(40), .IN_CH(IC), .NUM_FILT(NF), .FRAC_W(0), .RELU_EN(0))
        dut_nr (.clk(clk), .rst_n(rst), .bus(ifb));
    conv_calc_param #(.DATA_W(DW), .ACC_W(40), .IN_CH(IC), .NUM_FILT(NF), .FRAC_W(8), .RELU_EN(0))
        dut_fr (.clk(clk), .rst_n(rst), .bus(ifc));

    function automatic logic [9*DW-1:0] all_taps(input logic [DW-1:0] v);
        return {9{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int a, input logic [DW-1:0] d);
        ifa.cfg_we   = 1'b1;
        ifa.cfg_addr = AW'(a);
        ifa.cfg_data = d;
        tick();
        ifa.cfg_we   = 1'b0;
    endtask

    task automatic set_filter(input int f, input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int k = 0; k < 18; k++) cfg_wr(f*19 + k, w);
        cfg_wr(f*19 + 18, b);
    endtask

    task automatic send_win(input logic [9*DW-1:0] d);
        bit ok;
        ok = 1'b0;
        ifa.win_valid = 1'b1;
        ifa.win_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (ifa.win_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            $display("FAIL send_win: win_ready got %b required 1 within 20 cycles", ifa.win_ready);
            $fatal(1);
        end
        tick();
        ifa.win_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            $display("FAIL wait_out: out_valid got %b required 1 within 20 cycles", ifa.out_valid);
            $fatal(1);
        end
    endtask

    task automatic drain();
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL rst_win_ready got %b exp 0", ifa.win_ready); end
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ifa.out_valid); end
        checks++; if (ifa.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", ifa.out_data); end
        checks++; if (ifa.out_sat !== 2'b00) begin errors++; $display("FAIL rst_out_sat got %b exp 00", ifa.out_sat); end
        checks++; if (ifa.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b exp 0", ifa.cfg_err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifa.win_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", ifa.win_ready); end
        tick();
    endtask

    task automatic test_basic();
        set_filter(0, 16'd1, 16'd5);
        set_filter(1, 16'd1, 16'd5);
        checks++; if (ifa.cfg_err !== 1'b0) begin errors++; $display("FAIL basic_cfg_err got %b exp 0", ifa.cfg_err); end
        send_win(all_taps(16'd2));
        send_win(all_taps(16'd2));
        checks++; if (ifa.out_valid !== 1'b0 || ifa.win_ready !== 1'b0) begin errors++; $display("FAIL basic_finish valid/ready got %b%b exp 00", ifa.out_valid, ifa.win_ready); end
        tick();
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b exp 1", ifa.out_valid); end
        checks++; if (ifa.out_data !== 32'h0029_0029) begin errors++; $display("FAIL basic_data got %h exp 00290029", ifa.out_data); end
        checks++; if (ifa.out_sat !== 2'b00) begin errors++; $display("FAIL basic_sat got %b exp 00", ifa.out_sat); end
        drain();
        checks++; if (ifa.out_valid !== 1'b0 || ifa.win_ready !== 1'b1) begin errors++; $display("FAIL basic_release valid/ready got %b%b exp 01", ifa.out_valid, ifa.win_ready); end
    endtask

    task automatic test_sign_relu();
        set_filter(0, 16'hFFFF, 16'd0);
        send_win(all_taps(16'd3));
        send_win(all_taps(16'd3));
        wait_out();
        checks++; if (ifa.out_data !== {16'd59, 16'd0}) begin errors++; $display("FAIL relu_data got %h exp 003b0000", ifa.out_data); end
        checks++; if (ifa.out_sat !== 2'b00) begin errors++; $display("FAIL relu_sat got %b exp 00", ifa.out_sat); end
        checks++; if (ifb.out_data !== {16'd59, 16'hFFCA}) begin errors++; $display("FAIL norelu_data got %h exp 003bffca", ifb.out_data); end
        checks++; if (ifc.out_data !== {16'd0, 16'hFFFF}) begin errors++; $display("FAIL shift_neg_data got %h exp 0000ffff", ifc.out_data); end
        drain();
    endtask

    task automatic test_sat();
        set_filter(0, 16'h7FFF, 16'd0);
        set_filter(1, 16'h7FFF, 16'd0);
        send_win(all_taps(16'h7FFF));
        send_win(all_taps(16'h7FFF));
        wait_out();
        checks++; if (ifa.out_data !== 32'h7FFF_7FFF) begin errors++; $display("FAIL satpos_data got %h exp 7fff7fff", ifa.out_data); end
        checks++; if (ifa.out_sat !== 2'b11) begin errors++; $display("FAIL satpos_sat got %b exp 11", ifa.out_sat); end
        checks++; if (ifc.out_data !== 32'h7FFF_7FFF || ifc.out_sat !== 2'b11) begin errors++; $display("FAIL satpos_shift got %h/%b exp 7fff7fff/11", ifc.out_data, ifc.out_sat); end
        drain();
        send_win(all_taps(16'h8000));
        send_win(all_taps(16'h8000));
        wait_out();
        checks++; if (ifa.out_data !== 32'h0 || ifa.out_sat !== 2'b11) begin errors++; $display("FAIL satneg_relu got %h/%b exp 00000000/11", ifa.out_data, ifa.out_sat); end
        checks++; if (ifb.out_data !== 32'h8000_8000 || ifb.out_sat !== 2'b11) begin errors++; $display("FAIL satneg_norelu got %h/%b exp 80008000/11", ifb.out_data, ifb.out_sat); end
        drain();
        cfg_wr(0, 16'hFFFF);
        for (int k = 1; k < 18; k++) cfg_wr(k, 16'd0);
        send_win(144'h1);
        send_win(144'h0);
        wait_out();
        checks++; if (ifc.out_data !== {16'd127, 16'hFFFF} || ifc.out_sat !== 2'b00) begin errors++; $display("FAIL floor_shift got %h/%b exp 007fffff/00", ifc.out_data, ifc.out_sat); end
        checks++; if (ifb.out_data !== {16'h7FFF, 16'hFFFF} || ifb.out_sat !== 2'b00) begin errors++; $display("FAIL floor_noshift got %h/%b exp 7fffffff/00", ifb.out_data, ifb.out_sat); end
        drain();
    endtask

    task automatic test_backpressure();
        set_filter(0, 16'd1, 16'd5);
        set_filter(1, 16'd1, 16'd5);
        send_win(all_taps(16'd2));
        send_win(all_taps(16'd2));
        wait_out();
        ifa.win_valid = 1'b1;
        ifa.win_data  = all_taps(16'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, ifa.out_valid); end
            checks++; if (ifa.out_data !== 32'h0029_0029) begin errors++; $display("FAIL bp_data[%0d] got %h exp 00290029", i, ifa.out_data); end
            checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, ifa.win_ready); end
        end
        ifa.win_valid = 1'b0;
        drain();
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", ifa.out_valid); end
        send_win(all_taps(16'd1));
        send_win(all_taps(16'd1));
        wait_out();
        checks++; if (ifa.out_data !== 32'h0017_0017) begin errors++; $display("FAIL bp_next_data got %h exp 00170017", ifa.out_data); end
        drain();
    endtask

    task automatic test_cfg_gating();
        set_filter(0, 16'd1, 16'd0);
        send_win(all_taps(16'd1));
        cfg_wr(9, 16'd7);
        checks++; if (ifa.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_midch_err got %b exp 1", ifa.cfg_err); end
        tick();
        checks++; if (ifa.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got %b exp 0", ifa.cfg_err); end
        send_win(all_taps(16'd1));
        wait_out();
        checks++; if (ifa.out_data !== {16'd23, 16'd18}) begin errors++; $display("FAIL cfg_midch_data got %h exp 00170012", ifa.out_data); end
        drain();
        cfg_wr(38, 16'd7);
        checks++; if (ifa.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_oor38_err got %b exp 1", ifa.cfg_err); end
        cfg_wr(63, 16'd7);
        checks++; if (ifa.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_oor63_err got %b exp 1", ifa.cfg_err); end
        ifa.win_valid = 1'b1;
        ifa.win_data  = all_taps(16'd1);
        ifa.cfg_we    = 1'b1;
        ifa.cfg_addr  = AW'(9);
        ifa.cfg_data  = 16'd7;
        tick();
        ifa.cfg_we    = 1'b0;
        ifa.win_valid = 1'b0;
        checks++; if (ifa.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_collide_err got %b exp 1", ifa.cfg_err); end
        send_win(all_taps(16'd1));
        wait_out();
        checks++; if (ifa.out_data !== {16'd23, 16'd18}) begin errors++; $display("FAIL cfg_collide_data got %h exp 00170012", ifa.out_data); end
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen;
        send_win(all_taps(16'd2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (ifa.win_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state ready/valid got %b%b exp 10", ifa.win_ready, ifa.out_valid); end
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (ifa.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %b exp 0", seen); end
        send_win(all_taps(16'd2));
        send_win(all_taps(16'd2));
        wait_out();
        checks++; if (ifa.out_data !== 32'h0 || ifa.out_sat !== 2'b00) begin errors++; $display("FAIL rstmid_data got %h/%b exp 00000000/00", ifa.out_data, ifa.out_sat); end
        drain();
    endtask

    initial begin
        ifa.win_valid = 1'b0;
        ifa.win_data  = '0;
        ifa.cfg_we    = 1'b0;
        ifa.cfg_addr  = '0;
        ifa.cfg_data  = '0;
        ifa.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sign_relu();
        test_sat();
        test_backpressure();
        test_cfg_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
